// File: rtl/sprite_fetch_hit.sv
// sprite_fetch_hit: per-frame sprite register snapshot (shadow -> active) and five-sprite pixel hit test.
// Define SPRITE_XWRAP_EN for horizontal tunnel wrap of the x coverage test.
module sprite_fetch_hit #(
  parameter int SPRITE_SIZE = 16,
  parameter int NUM_REGS = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  output logic [5:0] reg_addr,
  input  logic [7:0] reg_data,
  input  logic [7:0] pix_x,
  input  logic [7:0] pix_y,
  output logic       hit,
  output logic [2:0] hit_id,
  output logic [1:0] hit_rot,
  output logic [3:0] hit_dx,
  output logic [3:0] hit_dy,
  output logic [7:0] map_x,
  output logic [7:0] map_y,
  output logic       busy,
  output logic       snapshot_valid
);
  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_t;
  localparam logic [8:0] SZ = 9'(SPRITE_SIZE);
  localparam logic [4:0] LAST = 5'(NUM_REGS - 1);
  state_t state;
  logic [4:0] cnt;
  logic [7:0] shadow [NUM_REGS];
  logic [7:0] active [NUM_REGS];
  logic [4:0][8:0] ex, ey;
  logic [4:0] cov;
  logic [13:0] nxt;
  assign reg_addr = {1'b0, cnt};
  assign map_x = active[3];
  assign map_y = active[4];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      snapshot_valid <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (frame_start) begin
          state <= FETCH;
          busy <= 1'b1;
        end
        FETCH: begin
          shadow[cnt] <= reg_data;
          cnt <= cnt == LAST ? '0 : cnt + 5'd1;
          if (cnt == LAST) begin
            state <= COMMIT;
            busy <= 1'b0;
          end
        end
        default: begin
          active <= shadow;
          snapshot_valid <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  // sprite s owns regs base..base+2 (x, y, rot); regs 3/4 are the map scroll
  for (genvar s = 0; s < 5; s++) begin : g_spr
    localparam int B = s == 0 ? 0 : 3 * s + 2;
    assign ex[s] = {1'b0, pix_x} - {1'b0, active[B]};
    assign ey[s] = {1'b0, pix_y} - {1'b0, active[B+1]};
`ifdef SPRITE_XWRAP_EN
    assign cov[s] = {1'b0, ex[s][7:0]} < SZ && ey[s] < SZ;
`else
    assign cov[s] = ex[s] < SZ && ey[s] < SZ;
`endif
  end
  always_comb begin
    nxt = '0;
    for (int i = 4; i >= 0; i--)
      if (cov[i]) nxt = {1'b1, 3'(i), active[i == 0 ? 2 : 3 * i + 4][1:0], ex[i][3:0], ey[i][3:0]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {hit, hit_id, hit_rot, hit_dx, hit_dy} <= '0;
    else {hit, hit_id, hit_rot, hit_dx, hit_dy} <= nxt;
endmodule

// File: tb/tb_sprite_fetch_hit.sv
// tb_sprite_fetch_hit: directed scoreboard bench for sprite_fetch_hit.
module tb_sprite_fetch_hit;
  logic clk = 0, rst_n = 1, frame_start = 0;
  logic [5:0] reg_addr;
  logic [7:0] reg_data, pix_x = 0, pix_y = 0, map_x, map_y;
  logic hit, busy, snapshot_valid;
  logic [2:0] hit_id;
  logic [1:0] hit_rot;
  logic [3:0] hit_dx, hit_dy;
  logic [7:0] rf [32];
  logic [7:0] act [17];
  logic [13:0] q [$];
  logic [13:0] hv;
  int cmp = 0, bad = 0;
  sprite_fetch_hit dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .reg_addr(reg_addr),
    .reg_data(reg_data), .pix_x(pix_x), .pix_y(pix_y), .hit(hit), .hit_id(hit_id),
    .hit_rot(hit_rot), .hit_dx(hit_dx), .hit_dy(hit_dy), .map_x(map_x), .map_y(map_y),
    .busy(busy), .snapshot_valid(snapshot_valid)
  );
  always #5 clk = ~clk;
  assign reg_data = rf[reg_addr[4:0]];
  assign hv = {hit, hit_id, hit_rot, hit_dx, hit_dy};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [13:0] model(input int x, input int y);
    int b, px, py, dx, dy;
    bit cx;
    model = '0;
    for (int s = 4; s >= 0; s--) begin
      b = s == 0 ? 0 : 3 * s + 2;
      px = act[b];
      py = act[b+1];
      dx = x - px;
      dy = y - py;
`ifdef SPRITE_XWRAP_EN
      dx = (dx + 256) % 256;
      cx = dx < 16;
`else
      cx = x >= px && dx < 16;
`endif
      if (cx && y >= py && dy < 16)
        model = {1'b1, 3'(s), act[b+2][1:0], 4'(dx), 4'(dy)};
    end
  endfunction
  task automatic pix_chk(input logic [7:0] x, input logic [7:0] y, input logic [13:0] e);
    @(negedge clk);
    pix_x = x;
    pix_y = y;
    q.push_back(e);
    @(negedge clk);
    chk("hit_vec", hv, q.pop_front());
  endtask
  task automatic sprite(input int s, input logic [7:0] x, input logic [7:0] y, input logic [7:0] r);
    int b;
    b = s == 0 ? 0 : 3 * s + 2;
    rf[b] = x;
    rf[b+1] = y;
    rf[b+2] = r;
  endtask
  task automatic fetch(input bit second);
    logic [13:0] e;
    int n;
    e = model(pix_x, pix_y);
    @(negedge clk) frame_start = 1;
    @(negedge clk) frame_start = 0;
    n = 0;
    while (busy && n < 40) begin
      chk("reg_addr", reg_addr, 6'(n));
      q.push_back(e);
      frame_start = second && n == 5;
      @(negedge clk);
      chk("hit_during_fetch", hv, q.pop_front());
      n++;
    end
    chk("busy_len", n, 17);
    frame_start = second;
    q.push_back(e);
    @(negedge clk);
    frame_start = 0;
    chk("snapshot_valid", snapshot_valid, 1'b1);
    chk("hit_at_commit", hv, q.pop_front());
    for (int k = 0; k < 17; k++) act[k] = rf[k];
    @(negedge clk);
    chk("no_refetch", busy, 1'b0);
  endtask
  initial begin
    for (int k = 0; k < 32; k++) rf[k] = 8'h10 + 8'(k);
    for (int k = 0; k < 17; k++) act[k] = 0;
    #1 rst_n = 0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", reg_addr, 6'd0);
    chk("rst_sv", snapshot_valid, 1'b0);
    chk("rst_hit", hv, 14'd0);
    chk("rst_map", {map_x, map_y}, 16'd0);
    @(negedge clk) rst_n = 1;
    fetch(0);
    chk("map_x", map_x, 8'h13);
    chk("map_y", map_y, 8'h14);
    pix_chk(8'h18, 8'h19, model(8'h18, 8'h19));
    pix_chk(8'h18, 8'h19, {1'b1, 3'd0, 2'd2, 4'd8, 4'd8});
    sprite(0, 40, 60, 2);
    sprite(1, 44, 62, 1);
    sprite(2, 100, 200, 3);
    sprite(3, 120, 200, 3);
    sprite(4, 140, 200, 3);
    rf[3] = 8'h33;
    rf[4] = 8'h44;
    fetch(0);
    chk("map_x2", map_x, 8'h33);
    pix_chk(45, 70, {1'b1, 3'd0, 2'd2, 4'd5, 4'd10});
    pix_chk(56, 60, 14'd0);
    pix_chk(46, 64, {1'b1, 3'd0, 2'd2, 4'd6, 4'd4});
    sprite(0, 0, 0, 2);
    fetch(1);
    pix_chk(46, 64, {1'b1, 3'd1, 2'd1, 4'd2, 4'd2});
    pix_chk(5, 5, {1'b1, 3'd0, 2'd2, 4'd5, 4'd5});
    pix_chk(46, 64, model(46, 64));
    @(negedge clk) frame_start = 1;
    @(negedge clk) frame_start = 0;
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr", reg_addr, 6'd0);
    chk("mid_rst_sv", snapshot_valid, 1'b0);
    chk("mid_rst_hit", hv, 14'd0);
    chk("mid_rst_map", {map_x, map_y}, 16'd0);
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 17; k++) act[k] = 0;
    sprite(0, 0, 128, 0);
    sprite(1, 40, 128, 0);
    sprite(2, 80, 128, 0);
    sprite(3, 120, 128, 0);
    sprite(4, 250, 0, 1);
    fetch(0);
`ifdef SPRITE_XWRAP_EN
    pix_chk(3, 4, {1'b1, 3'd4, 2'd1, 4'd9, 4'd4});
`else
    pix_chk(3, 4, 14'd0);
`endif
    pix_chk(252, 2, {1'b1, 3'd4, 2'd1, 4'd2, 4'd2});
    pix_chk(255, 15, {1'b1, 3'd4, 2'd1, 4'd5, 4'd15});
    pix_chk(249, 0, 14'd0);
    pix_chk(252, 16, 14'd0);
    for (int k = 0; k < 40; k++) begin
      logic [7:0] x, y;
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(120, 150));
      if (k % 4 == 0) y = 8'($urandom_range(0, 20));
      pix_chk(x, y, model(x, y));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
